// File: rtl/rot_pattern_gen.sv
// Rotating pattern generator: streams seed bytes rotated through an
// external bshifter, with the rotated result fed back as the next value.
module rot_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_step,
    input  logic             in_lr,
    input  logic [CNT_W-1:0] in_count,
    output logic [WIDTH-1:0] sh_a,
    output logic [2:0]       sh_amt,
    output logic             sh_lr,
    input  logic [WIDTH-1:0] sh_mout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    localparam logic [CNT_W:0] REM_ONE = (CNT_W+1)'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [2:0]       step_q, step_d;
    logic             dir_q, dir_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             load;

    assign in_ready  = (state_q == IDLE);
    assign sh_a      = cur_q;
    assign sh_amt    = step_q;
    assign sh_lr     = dir_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

    assign load = (state_q == RUN) && (!vld_q || out_ready) &&
                  (rem_q != '0);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        step_d  = step_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        vld_d   = vld_q;
        data_d  = data_q;
        last_d  = last_q;
        if (clr) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cur_d   = in_data;
                        step_d  = in_step;
                        dir_d   = in_lr;
                        // A zero count sets the top bit: 2**CNT_W outputs
                        rem_d   = {(in_count == '0), in_count};
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        data_d = sh_mout;
                        cur_d  = sh_mout;
                        vld_d  = 1'b1;
                        rem_d  = rem_q - REM_ONE;
                        last_d = (rem_q == REM_ONE);
                        if (rem_q == REM_ONE) begin
                            state_d = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (vld_q && out_ready) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            step_q  <= '0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_rot_pattern_gen.sv
// Scoreboard bench for rot_pattern_gen with a behavioural bshifter and
// a rotation reference model.
module tb_rot_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_step = '0;
    logic       in_lr = 1'b0;
    logic [3:0] in_count = '0;
    logic [7:0] sh_a;
    logic [2:0] sh_amt;
    logic       sh_lr;
    logic [7:0] sh_mout;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;

    int total = 0;
    int bad = 0;
    int popped = 0;
    logic rnd_ready = 1'b0;
    logic ready_force = 1'b1;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    rot_pattern_gen #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_step(in_step), .in_lr(in_lr),
        .in_count(in_count),
        .sh_a(sh_a), .sh_amt(sh_amt), .sh_lr(sh_lr), .sh_mout(sh_mout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    // External rotator: bit i moves amt places left or right
    always_comb begin
        sh_mout = '0;
        for (int i = 0; i < 8; i++) begin
            if (sh_lr) sh_mout[(i + int'(sh_amt)) % 8] = sh_a[i];
            else       sh_mout[(i + 8 - int'(sh_amt)) % 8] = sh_a[i];
        end
    end

    function automatic logic [7:0] rot(input logic [7:0] s,
                                       input int n, input logic lr);
        int k;
        logic [15:0] w;
        k = n % 8;
        w = {s, s};
        if (lr) return w[15 - k -: 8];
        return w[7 + k -: 8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    initial begin
        logic       stall_prev = 1'b0;
        logic [8:0] held = '0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && out_valid)
                    chk("held", {out_last, out_data}, held);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra byte: got %0h expected none",
                                 out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", {out_last, out_data}, e);
                    end
                    popped++;
                end
                stall_prev = out_valid && !out_ready;
                held = {out_last, out_data};
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic [2:0] st,
                        input logic lr, input logic [3:0] cnt);
        int n;
        int waited;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) chk("accept timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = s;
        in_step  = st;
        in_lr    = lr;
        in_count = cnt;
        n = (cnt == 0) ? 16 : int'(cnt);
        for (int i = 1; i <= n; i++)
            exp_q.push_back({(i == n), rot(s, i * int'(st), lr)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || !in_ready) && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", exp_q.size(), 0);
        chk("idle", in_ready, 1);
    endtask

    task automatic wait_pops(input int target);
        int c;
        c = 0;
        while (popped < target && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("pop wait", (popped >= target), 1);
    endtask

    initial begin
        int base;
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_last", out_last, 0);
        chk("rst sh", {sh_a, sh_amt, sh_lr}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Left chase with per-cycle throughput checks
        send(8'h01, 3'd1, 1'b1, 4'd8);
        chk("latency", out_valid, 0);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            chk("no bubble", out_valid, 1);
            chk("chase data", out_data, rot(8'h01, n, 1'b1));
        end
        chk("flush busy", in_ready, 0);
        @(posedge clk);
        #1;
        chk("chase idle", {in_ready, out_valid}, 2'b10);
        wait_done();

        send(8'hAA, 3'd1, 1'b0, 4'd2);
        wait_done();
        send(8'h80, 3'd2, 1'b0, 4'd3);
        wait_done();

        // Stall the first byte for three cycles
        ready_force = 1'b0;
        send(8'h01, 3'd3, 1'b1, 4'd4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall data", {out_valid, out_data}, {1'b1, 8'h08});
        end
        ready_force = 1'b1;
        wait_done();

        send(8'h5A, 3'd0, 1'b0, 4'd0);
        wait_done();

        // Synchronous abort after the second byte
        base = popped;
        send(8'h81, 3'd1, 1'b1, 4'd8);
        wait_pops(base + 2);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hFF;
        in_count = 4'd3;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("clr valid", out_valid, 0);
        chk("clr ready", in_ready, 1);
        send(8'h0F, 3'd4, 1'b0, 4'd3);
        wait_done();

        // Asynchronous reset mid-run
        base = popped;
        send(8'h33, 3'd2, 1'b1, 4'd8);
        wait_pops(base + 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst outs", {out_valid, out_last, out_data}, 0);
        chk("arst ready", in_ready, 1);
        chk("arst sh", {sh_a, sh_amt, sh_lr}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'hC3, 3'd1, 1'b0, 4'd5);
        wait_done();

        // Command offered while busy must be ignored
        send(8'h3C, 3'd1, 1'b0, 4'd6);
        @(posedge clk);
        #1;
        chk("busy ready", in_ready, 0);
        in_valid = 1'b1;
        in_data = 8'hFF;
        in_count = 4'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        chk("busy no extra", out_valid, 0);

        // Random commands under random backpressure
        rnd_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            send(8'($urandom), 3'($urandom), 1'($urandom),
                 4'($urandom));
            wait_done();
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rot_pattern_gen.md
Name: rot_pattern_gen

Overview:
Sequential pattern generator that sits upstream of the 8-bit combinational rotator `bshifter`. It accepts one command: a seed byte, a step amount, a direction and a repeat count. It then feeds its current value through `bshifter` with the result fed back, and streams each rotated byte out on a valid/ready interface. Its typical use is LED-chaser and test-pattern generation on the FPGA.

Parameters:
WIDTH, 8, data width; fixed to 8 to match bshifter; other values unsupported.
CNT_W, 4, width of repeat count; 0 encodes 2**CNT_W outputs.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous abort; drops the current command.
in_valid  in  1  command valid.
in_ready  out  1  block can accept a command.
in_data  in  WIDTH  seed byte.
in_step  in  3  rotate amount per output (0..7).
in_lr  in  1  direction: 0 = rotate right, 1 = rotate left (bshifter encoding).
in_count  in  CNT_W  number of outputs; 0 means 2**CNT_W.
sh_a  out  WIDTH  to bshifter.a; equals cur register.
sh_amt  out  3  to bshifter.amt; equals step register.
sh_lr  out  1  to bshifter.lr; equals dir register.
sh_mout  in  WIDTH  from bshifter.mout; combinational rotate of sh_a.
out_valid  out  1  output byte valid.
out_ready  in  1  downstream accepts the byte.
out_data  out  WIDTH  rotated byte.
out_last  out  1  high with the final byte of a command.

Behaviour:
- Reset (rst_n low, asynchronous), all registers cleared:
  - state = IDLE, cur = 0, step = 0, dir = 0, remaining = 0.
  - out_valid = 0, out_data = 0, out_last = 0, in_ready = 1.
- sh_a, sh_amt and sh_lr are direct register outputs: no combinational path from any input.
- in_ready = 1 only in IDLE.
- Accept rule: in IDLE, in_valid & in_ready at an edge:
  - cur <= in_data, step <= in_step, dir <= in_lr.
  - remaining <= in_count, or 2**CNT_W when in_count == 0 (remaining is CNT_W+1 bits).
  - state <= RUN.
- States:
  - IDLE: waits for a command.
  - RUN: generates bytes.
  - FLUSH: all bytes generated, waiting for the last byte to drain.
- Output register: single-entry; a byte is held while out_valid & !out_ready.
- Load condition in RUN: (!out_valid | out_ready) and remaining != 0. On load:
  - out_data <= sh_mout, cur <= sh_mout, out_valid <= 1.
  - remaining <= remaining - 1.
  - out_last <= (remaining == 1).
  - If remaining == 1, state <= FLUSH.
- In RUN with out_valid & out_ready and no load (cannot occur while remaining != 0): not reachable; no special handling.
- In FLUSH: when out_valid & out_ready, then out_valid <= 0, out_last <= 0, state <= IDLE. in_ready rises the following cycle.
- Latency: command accepted at edge k, so the first out_valid is seen after edge k+1.
- Throughput: with out_ready held high, one byte per clock, N bytes on edges k+1..k+N, IDLE after edge k+N+1. No bubbles while out_ready is high.
- Output n (1-based) = seed rotated by n*step in direction dir, modulo 8 positions.
- step = 0 is legal: every output equals the seed.
- out_data and out_last are stable while out_valid & !out_ready. No byte is skipped or duplicated.
- clr (synchronous) has priority over all other actions:
  - state <= IDLE, out_valid <= 0, out_last <= 0, remaining <= 0.
  - cur, step and dir hold their values.
  - A command presented in the same cycle as clr is not accepted.
- Asynchronous reset mid-command: returns immediately to reset values; the partial stream is discarded.
- in_valid outside IDLE is ignored; the command is not latched.

Test Plan:
- Left-chase seed: in_data=8'h01, in_step=1, in_lr=1, in_count=8, out_ready=1.
  - Bytes 02,04,08,10,20,40,80,01 on consecutive cycles; out_last only with 01; in_ready=1 two cycles after the last accept-to-output edge.
- Right rotate: in_data=8'hAA, step=1, lr=0, count=2 → 55, AA.
  - Then in_data=8'h80, step=2, lr=0, count=3 → 20, 08, 02 with out_last on 02.
- Backpressure: seed 8'h01, step=3, lr=1, count=4; drop out_ready for 3 cycles after the first byte.
  - Byte 08 is held stable for the whole stall.
  - Full sequence 08, 40, 02, 10 with none skipped or duplicated.
- Count wrap: in_count=0, step=0, seed 8'h5A → exactly 16 bytes of 5A, out_last on the 16th.
- Abort/reset:
  - Assert clr after the 2nd byte of a count=8 command → out_valid=0 next cycle, in_ready=1; a new command is then accepted normally.
  - Repeat with rst_n pulsed low mid-run → outputs at reset values immediately, without waiting for a clock edge.
- Ignore while busy: pulse in_valid with in_data=8'hFF during RUN → the stream is unaffected and the FF command is never produced.
